// File: rtl/ex_branch_unit.sv
// Branch/jump execute unit: six compare conditions, register jumps and
// returns, optional link to r63, and a circular return-address stack that
// checks return targets. All results are registered; commit stall freezes
// every register in the unit.
module ex_branch_unit #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] next_pc,
  input  logic [3:0]      op,
  input  logic            ex_enable,
  input  logic            stall,
  output logic            ex_busy,
  output logic [XLEN-1:0] jump_pc,
  output logic            do_jump,
  output logic [XLEN-1:0] link_val,
  output logic            link_update,
  output logic            ret_hit,
  output logic            ras_valid
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    C_EQ  = 3'd0,
    C_NE  = 3'd1,
    C_LT  = 3'd2,
    C_GE  = 3'd3,
    C_LTU = 3'd4,
    C_GEU = 3'd5,
    C_JR  = 3'd6,
    C_RET = 3'd7
  } cond_e;

  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;    // next free slot; top of stack is r_ptr-1
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_jump_pc;
  logic            r_do_jump;
  logic [XLEN-1:0] r_link_val;
  logic            r_link_update;
  logic            r_ret_hit;

  cond_e           w_cond;
  logic            w_accept;
  logic            w_taken;
  logic            w_link;
  logic            w_is_ret;
  logic            w_nonempty;
  logic [PW-1:0]   w_top_idx;
  logic [XLEN-1:0] w_target;

  assign w_cond     = cond_e'(op[2:0]);
  assign w_accept   = ex_enable & ~stall;
  assign w_link     = op[3];
  assign w_is_ret   = (w_cond == C_RET);
  assign w_nonempty = (r_count != '0);
  assign w_top_idx  = r_ptr - 1'b1;

  // Condition evaluation and redirect target selection.
  always_comb begin
    w_taken  = 1'b0;
    w_target = next_pc + imm;
    unique case (w_cond)
      C_EQ:  w_taken = (in1 == in2);
      C_NE:  w_taken = (in1 != in2);
      C_LT:  w_taken = ($signed(in1) <  $signed(in2));
      C_GE:  w_taken = ($signed(in1) >= $signed(in2));
      C_LTU: w_taken = (in1 <  in2);
      C_GEU: w_taken = (in1 >= in2);
      C_JR, C_RET: begin
        w_taken  = 1'b1;
        w_target = in1;
      end
      default: w_taken = 1'b0;
    endcase
  end

  // Result registers and RAS update; stall holds everything, reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_jump_pc     <= '0;
      r_do_jump     <= 1'b0;
      r_link_val    <= '0;
      r_link_update <= 1'b0;
      r_ret_hit     <= 1'b0;
      r_ptr         <= '0;
      r_count       <= '0;
    end else if (!stall) begin
      r_do_jump     <= w_accept & w_taken;
      r_jump_pc     <= (w_accept & w_taken) ? w_target : '0;
      r_link_update <= w_accept & w_link;
      r_link_val    <= (w_accept & w_link) ? next_pc : '0;
      r_ret_hit     <= w_accept & w_is_ret & w_nonempty &
                       (r_ras[w_top_idx] == in1);
      if (w_accept) begin
        // Linked RET on a non-empty stack swaps the top in place; on an
        // empty stack it falls through to an ordinary push.
        if (w_is_ret && w_nonempty) begin
          if (w_link) begin
            r_ras[w_top_idx] <= next_pc;
          end else begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - 1'b1;
          end
        end else if (w_link) begin
          r_ras[r_ptr] <= next_pc;
          r_ptr        <= r_ptr + 1'b1;
          if (r_count != FULL) begin
            r_count <= r_count + 1'b1;
          end
        end
      end
    end
  end

  assign ex_busy     = stall;
  assign jump_pc     = r_jump_pc;
  assign do_jump     = r_do_jump;
  assign link_val    = r_link_val;
  assign link_update = r_link_update;
  assign ret_hit     = r_ret_hit;
  assign ras_valid   = w_nonempty;

endmodule

// File: tb/tb_ex_branch_unit.sv
// Bench for ex_branch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ex_branch_unit;

  localparam int unsigned XLEN = 64;
  localparam int unsigned DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] in1, in2, imm, next_pc;
  logic [3:0]      op;
  logic            ex_enable, stall;
  logic            ex_busy, do_jump, link_update, ret_hit, ras_valid;
  logic [XLEN-1:0] jump_pc, link_val;

  int n_checks = 0;
  int n_errors = 0;

  ex_branch_unit #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .imm(imm),
    .next_pc(next_pc), .op(op), .ex_enable(ex_enable), .stall(stall),
    .ex_busy(ex_busy), .jump_pc(jump_pc), .do_jump(do_jump),
    .link_val(link_val), .link_update(link_update), .ret_hit(ret_hit),
    .ras_valid(ras_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the RAS is a plain queue, newest at the back.
  logic [XLEN-1:0] m_ras[$];
  logic [XLEN-1:0] e_jump_pc, e_link_val;
  logic            e_do_jump, e_link_update, e_ret_hit;

  function automatic logic cond_taken(input logic [2:0] c,
                                      input logic [XLEN-1:0] a, b);
    case (c)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return $signed(a) < $signed(b);
      3'd3: return $signed(a) >= $signed(b);
      3'd4: return a < b;
      3'd5: return a >= b;
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      e_jump_pc = '0; e_do_jump = 0; e_link_val = '0;
      e_link_update = 0; e_ret_hit = 0;
      m_ras.delete();
    end else if (!stall) begin
      e_jump_pc = '0; e_do_jump = 0; e_link_val = '0;
      e_link_update = 0; e_ret_hit = 0;
      if (ex_enable) begin
        if (cond_taken(op[2:0], in1, in2)) begin
          e_do_jump = 1;
          e_jump_pc = (op[2:1] == 2'b11) ? in1 : next_pc + imm;
        end
        if (op[3]) begin
          e_link_update = 1;
          e_link_val = next_pc;
        end
        if (op[2:0] == 3'd7 && m_ras.size() > 0) begin
          e_ret_hit = (m_ras[$] == in1);
          if (op[3]) m_ras[$] = next_pc;
          else void'(m_ras.pop_back());
        end else if (op[3]) begin
          m_ras.push_back(next_pc);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("m.do_jump", {63'd0, do_jump}, {63'd0, e_do_jump});
    chk("m.jump_pc", jump_pc, e_jump_pc);
    chk("m.link_update", {63'd0, link_update}, {63'd0, e_link_update});
    chk("m.link_val", link_val, e_link_val);
    chk("m.ret_hit", {63'd0, ret_hit}, {63'd0, e_ret_hit});
    chk("m.ras_valid", {63'd0, ras_valid}, {63'd0, m_ras.size() != 0});
    chk("m.ex_busy", {63'd0, ex_busy}, {63'd0, stall});
  end

  task automatic drive(input logic en, input logic st, input logic [3:0] o,
                       input logic [XLEN-1:0] a, b, im, np);
    @(negedge clk);
    rst = 0; ex_enable = en; stall = st; op = o;
    in1 = a; in2 = b; imm = im; next_pc = np;
  endtask

  task automatic expect_out(input string tag, input logic dj,
                            input logic [XLEN-1:0] jp, input logic lu,
                            input logic [XLEN-1:0] lv, input logic rh,
                            input logic rv);
    @(posedge clk);
    #2;
    chk({tag, ".do_jump"}, {63'd0, do_jump}, {63'd0, dj});
    chk({tag, ".jump_pc"}, jump_pc, jp);
    chk({tag, ".link_update"}, {63'd0, link_update}, {63'd0, lu});
    chk({tag, ".link_val"}, link_val, lv);
    chk({tag, ".ret_hit"}, {63'd0, ret_hit}, {63'd0, rh});
    chk({tag, ".ras_valid"}, {63'd0, ras_valid}, {63'd0, rv});
  endtask

  localparam logic [XLEN-1:0] ONES = '1;

  initial begin
    rst = 1; ex_enable = 0; stall = 0; op = '0;
    in1 = '0; in2 = '0; imm = '0; next_pc = '0;
    expect_out("reset", 0, '0, 0, '0, 0, 0);

    // Signed versus unsigned compare of -1 against 1.
    drive(1, 0, 4'b0010, ONES, 64'd1, 64'h20, 64'h100);
    expect_out("blt", 1, 64'h120, 0, '0, 0, 0);
    drive(1, 0, 4'b0100, ONES, 64'd1, 64'h20, 64'h100);
    expect_out("bltu", 0, '0, 0, '0, 0, 0);
    drive(1, 0, 4'b0101, ONES, 64'd1, 64'h20, 64'h100);
    expect_out("bgeu", 1, 64'h120, 0, '0, 0, 0);
    drive(1, 0, 4'b0000, 64'd5, 64'd5, -64'sd8, 64'h1000);
    expect_out("beq", 1, 64'hFF8, 0, '0, 0, 0);
    drive(1, 0, 4'b0000, 64'd5, 64'd5, 64'h10, 64'hFFFF_FFFF_FFFF_FFF8);
    expect_out("wrap", 1, 64'h8, 0, '0, 0, 0);

    // Call / return / return on empty stack.
    drive(1, 0, 4'b1110, 64'h4000, 64'd0, 64'd0, 64'h104);
    expect_out("call", 1, 64'h4000, 1, 64'h104, 0, 1);
    drive(1, 0, 4'b0111, 64'h104, 64'd0, 64'd0, 64'h4010);
    expect_out("ret1", 1, 64'h104, 0, '0, 1, 0);
    drive(1, 0, 4'b0111, 64'h104, 64'd0, 64'd0, 64'h4010);
    expect_out("ret2", 1, 64'h104, 0, '0, 0, 0);

    // Overflow: nine calls into eight entries loses the oldest.
    for (int i = 1; i <= 9; i++) begin
      drive(1, 0, 4'b1110, 64'h5000 + 64'(i), 64'd0, 64'd0, 64'(i));
      expect_out("ovf_call", 1, 64'h5000 + 64'(i), 1, 64'(i), 0, 1);
    end
    for (int i = 9; i >= 2; i--) begin
      drive(1, 0, 4'b0111, 64'(i), 64'd0, 64'd0, 64'h77);
      expect_out("ovf_ret", 1, 64'(i), 0, '0, 1, i != 2);
    end
    drive(1, 0, 4'b0111, 64'd1, 64'd0, 64'd0, 64'h77);
    expect_out("ovf_ret9", 1, 64'd1, 0, '0, 0, 0);

    // Stall hold: taken BNE, then a linked BEQ held by dispatch under stall.
    drive(1, 0, 4'b0001, 64'd1, 64'd2, 64'h40, 64'h200);
    expect_out("bne", 1, 64'h240, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 4'b1000, 64'd7, 64'd7, 64'd0, 64'h300);
      expect_out("stall", 1, 64'h240, 0, '0, 0, 0);
      chk("stall.ex_busy", {63'd0, ex_busy}, 64'd1);
    end
    drive(1, 0, 4'b1000, 64'd7, 64'd7, 64'd0, 64'h300);
    expect_out("unstall", 1, 64'h300, 1, 64'h300, 0, 1);
    chk("unstall.ex_busy", {63'd0, ex_busy}, 64'd0);

    // Reset while stalled with a redirect held.
    drive(1, 0, 4'b0001, 64'd1, 64'd2, 64'h40, 64'h200);
    expect_out("bne2", 1, 64'h240, 0, '0, 0, 1);
    @(negedge clk);
    rst = 1; stall = 1;
    expect_out("rst_stall", 0, '0, 0, '0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 99) == 0);
      ex_enable = ($urandom_range(0, 99) < 75);
      stall     = ($urandom_range(0, 99) < 20);
      op        = 4'($urandom);
      in1       = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: in2 = in1;
        1: in2 = 64'($urandom_range(0, 3));
        default: in2 = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 3) == 0) in1 = 64'($urandom_range(0, 3));
      imm     = {$urandom, $urandom};
      next_pc = {$urandom, $urandom};
      if (op[2:0] == 3'd7 && m_ras.size() > 0 && $urandom_range(0, 1) == 1)
        in1 = m_ras[$];
    end
    @(negedge clk);
    rst = 0; ex_enable = 0; stall = 0;
    repeat (2) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
